spi_miso_arbiter: RTL and testbench

//  Parametrised, registered successor to the 8-way SPI slave MISO mux. Selects one of NUM_SLAVES slave

---
 rtl/spi_mux_pkg.sv | 40 ++++
 rtl/spi_mux_sync.sv | 41 ++++
 rtl/spi_miso_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_spi_miso_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mux_pkg.sv
// Shared types and helpers for the SPI MISO arbiter: FSM states, limits,
// popcount / one-hot helpers used on the synchronised enable vector.
package spi_mux_pkg;

    localparam int MAX_SLAVES = 32;
    localparam int MAX_SYNC   = 3;
    localparam int CNT_BITS   = 6;
    localparam int IDX_BITS   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_t;

    function automatic logic [CNT_BITS-1:0] popcount(input logic [MAX_SLAVES-1:0] v);
        logic [CNT_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            c = c + CNT_BITS'(v[i]);
        end
        return c;
    endfunction

    function automatic logic is_onehot(input logic [MAX_SLAVES-1:0] v);
        return (popcount(v) == 6'd1);
    endfunction

    function automatic logic [IDX_BITS-1:0] onehot_to_idx(input logic [MAX_SLAVES-1:0] v);
        logic [IDX_BITS-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            if (v[i]) begin
                idx = IDX_BITS'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_mux_sync.sv
// Multi-stage synchroniser for the combined enable/data bus, async-reset to 0.
// A depth of 0 passes the input straight through.
module spi_mux_sync
    import spi_mux_pkg::*;
#(
    parameter int W      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    localparam int DEPTH = (STAGES > MAX_SYNC) ? MAX_SYNC : STAGES;

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_sync
            logic [W-1:0] r_stage [DEPTH];

            // Shift chain; stage 0 captures the asynchronous inputs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/spi_miso_arbiter.sv
// Registered SPI MISO arbiter with guard-time hand-over and contention detection.
// Optional saturating contention counter: define SPI_MISO_ARB_CONTENTION_CNT_EN.
module spi_miso_arbiter
    import spi_mux_pkg::*;
#(
    parameter int   NUM_SLAVES   = 8,
    parameter int   SYNC_STAGES  = 2,
    parameter int   GUARD_CYCLES = 2,
    parameter logic IDLE_LEVEL   = 1'b0
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
    ,
    parameter int   CNT_W        = 8
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SLAVES-1:0]         miso_in,
    input  logic [NUM_SLAVES-1:0]         oen_in,
    input  logic                          err_clr,
    output logic                          miso_out,
    output logic                          oen_out,
    output logic [$clog2(NUM_SLAVES)-1:0] owner_idx,
    output logic                          owner_valid,
    output logic                          contention,
    output logic                          err_sticky
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
    ,
    output logic [CNT_W-1:0]              contention_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SLAVES);
    localparam int GC_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    logic [2*NUM_SLAVES-1:0] w_sync;
    logic [NUM_SLAVES-1:0]   w_oen_s;
    logic [NUM_SLAVES-1:0]   w_miso_s;
    logic [MAX_SLAVES-1:0]   w_oen_ext;
    logic [NUM_SLAVES-1:0]   w_owner_mask;
    logic                    w_onehot;
    logic                    w_multi;
    logic                    w_owner_match;
    logic [IDX_W-1:0]        w_new_idx;

    arb_state_t              r_state;
    logic [GC_W-1:0]         r_guard_cnt;
    logic [IDX_W-1:0]        r_owner_idx;
    logic                    r_owner_valid;
    logic                    r_oen_out;
    logic                    r_miso_out;
    logic                    r_contention;
    logic                    r_err_sticky;

    spi_mux_sync #(
        .W      (2 * NUM_SLAVES),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({oen_in, miso_in}),
        .o_q   (w_sync)
    );

    assign w_oen_s  = w_sync[2*NUM_SLAVES-1:NUM_SLAVES];
    assign w_miso_s = w_sync[NUM_SLAVES-1:0];

    // Enable-vector decode: one-hot / multi-hot classification and owner match
    always_comb begin
        w_oen_ext                  = '0;
        w_oen_ext[NUM_SLAVES-1:0]  = w_oen_s;
        w_owner_mask               = '0;
        w_owner_mask[r_owner_idx]  = 1'b1;
        w_onehot                   = is_onehot(w_oen_ext);
        w_multi                    = (popcount(w_oen_ext) >= 6'd2);
        w_new_idx                  = IDX_W'(onehot_to_idx(w_oen_ext));
        w_owner_match              = (w_oen_s == w_owner_mask);
    end

    // Hand-over FSM; pad outputs are registered alongside the state so they change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_guard_cnt   <= '0;
            r_owner_idx   <= '0;
            r_owner_valid <= 1'b0;
            r_oen_out     <= 1'b0;
            r_miso_out    <= IDLE_LEVEL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_guard_cnt <= '0;
                    if (w_onehot) begin
                        r_owner_idx   <= w_new_idx;
                        r_owner_valid <= 1'b1;
                        if (GUARD_CYCLES == 0) begin
                            r_state    <= ST_ACTIVE;
                            r_oen_out  <= 1'b1;
                            r_miso_out <= w_miso_s[w_new_idx];
                        end else begin
                            r_state    <= ST_GUARD;
                            r_oen_out  <= 1'b0;
                            r_miso_out <= IDLE_LEVEL;
                        end
                    end else begin
                        r_state       <= ST_IDLE;
                        r_owner_idx   <= '0;
                        r_owner_valid <= 1'b0;
                        r_oen_out     <= 1'b0;
                        r_miso_out    <= IDLE_LEVEL;
                    end
                end
                ST_GUARD: begin
                    if (!w_owner_match) begin
                        r_state       <= ST_IDLE;
                        r_guard_cnt   <= '0;
                        r_owner_idx   <= '0;
                        r_owner_valid <= 1'b0;
                        r_oen_out     <= 1'b0;
                        r_miso_out    <= IDLE_LEVEL;
                    end else if (r_guard_cnt == GC_W'(GUARD_CYCLES - 1)) begin
                        r_state     <= ST_ACTIVE;
                        r_guard_cnt <= '0;
                        r_oen_out   <= 1'b1;
                        r_miso_out  <= w_miso_s[r_owner_idx];
                    end else begin
                        r_state     <= ST_GUARD;
                        r_guard_cnt <= r_guard_cnt + GC_W'(1);
                        r_oen_out   <= 1'b0;
                        r_miso_out  <= IDLE_LEVEL;
                    end
                end
                ST_ACTIVE: begin
                    r_guard_cnt <= '0;
                    if (w_owner_match) begin
                        r_state    <= ST_ACTIVE;
                        r_oen_out  <= 1'b1;
                        r_miso_out <= w_miso_s[r_owner_idx];
                    end else begin
                        // any change of enables, including a new single owner, goes back through IDLE
                        r_state       <= ST_IDLE;
                        r_owner_idx   <= '0;
                        r_owner_valid <= 1'b0;
                        r_oen_out     <= 1'b0;
                        r_miso_out    <= IDLE_LEVEL;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_guard_cnt   <= '0;
                    r_owner_idx   <= '0;
                    r_owner_valid <= 1'b0;
                    r_oen_out     <= 1'b0;
                    r_miso_out    <= IDLE_LEVEL;
                end
            endcase
        end
    end

    // Contention pulse and sticky error; a new contention beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contention <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_contention <= w_multi;
            if (w_multi) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end else begin
                r_err_sticky <= r_err_sticky;
            end
        end
    end

`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
    logic [CNT_W-1:0] r_contention_cnt;

    // Saturating contention counter; clear with simultaneous contention yields 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contention_cnt <= '0;
        end else if (err_clr) begin
            r_contention_cnt <= w_multi ? CNT_W'(1) : '0;
        end else if (w_multi && (r_contention_cnt != {CNT_W{1'b1}})) begin
            r_contention_cnt <= r_contention_cnt + CNT_W'(1);
        end else begin
            r_contention_cnt <= r_contention_cnt;
        end
    end

    assign contention_cnt = r_contention_cnt;
`endif

    assign miso_out    = r_miso_out;
    assign oen_out     = r_oen_out;
    assign owner_idx   = r_owner_idx;
    assign owner_valid = r_owner_valid;
    assign contention  = r_contention;
    assign err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_spi_miso_arbiter.sv
// Self-checking bench for spi_miso_arbiter: directed scenarios plus randomized
// enable/data traffic compared against an ownership-age reference model.
module tb_spi_miso_arbiter;

    localparam int   N       = 8;
    localparam int   SYNC    = 2;
    localparam int   G       = 2;
    localparam logic IDLE    = 1'b0;
    localparam int   CNT_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] miso_in;
    logic [7:0] oen_in;
    logic       err_clr;
    logic       miso_out;
    logic       oen_out;
    logic [2:0] owner_idx;
    logic       owner_valid;
    logic       contention;
    logic       err_sticky;
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
    logic [1:0] contention_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: enables/data seen through a SYNC-deep delay line,
    // ownership tracked as the age of an uninterrupted one-hot grant
    logic [7:0] d_oen  [SYNC];
    logic [7:0] d_miso [SYNC];
    int         m_age;
    int         m_owner;
    int         m_cnt;
    logic       m_oen_out, m_miso_out, m_valid, m_contention, m_err;
    logic [2:0] m_idx;

    spi_miso_arbiter #(
        .NUM_SLAVES   (N),
        .SYNC_STAGES  (SYNC),
        .GUARD_CYCLES (G),
        .IDLE_LEVEL   (IDLE)
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
        ,
        .CNT_W        (2)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miso_in        (miso_in),
        .oen_in         (oen_in),
        .err_clr        (err_clr),
        .miso_out       (miso_out),
        .oen_out        (oen_out),
        .owner_idx      (owner_idx),
        .owner_valid    (owner_valid),
        .contention     (contention),
        .err_sticky     (err_sticky)
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
        ,
        .contention_cnt (contention_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < SYNC; i++) begin
            d_oen[i]  = 8'd0;
            d_miso[i] = 8'd0;
        end
        m_age = -1; m_owner = 0; m_cnt = 0;
        m_oen_out = 1'b0; m_miso_out = IDLE; m_valid = 1'b0;
        m_contention = 1'b0; m_err = 1'b0; m_idx = 3'd0;
    endtask

    task automatic tick();
        logic [7:0] s_oen;
        logic [7:0] s_miso;
        int         pc;
        @(posedge clk);
        s_oen  = d_oen[SYNC-1];
        s_miso = d_miso[SYNC-1];
        pc = $countones(s_oen);
        m_contention = (pc >= 2);
        if (pc >= 2) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (err_clr) m_cnt = (pc >= 2) ? 1 : 0;
        else if (pc >= 2 && m_cnt < CNT_MAX) m_cnt++;
        if (m_age < 0) begin
            if (pc == 1) begin
                m_owner = $clog2(s_oen);
                m_age   = 0;
            end
        end else if (s_oen != (8'd1 << m_owner)) begin
            m_age   = -1;
            m_owner = 0;
        end else if (m_age < G) begin
            m_age++;
        end
        m_valid    = (m_age >= 0);
        m_oen_out  = (m_age >= G);
        m_idx      = m_valid ? 3'(m_owner) : 3'd0;
        m_miso_out = m_oen_out ? s_miso[m_owner] : IDLE;
        for (int i = SYNC - 1; i > 0; i--) begin
            d_oen[i]  = d_oen[i-1];
            d_miso[i] = d_miso[i-1];
        end
        d_oen[0]  = oen_in;
        d_miso[0] = miso_in;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0; oen_in = 8'd0; miso_in = 8'd0; err_clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
        checks++;
        if (got !== 8'b0000_0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", got, 8'b0000_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
            checks++;
            if (got !== 8'b0000_0000) begin
                errors++;
                $display("FAIL reset_idle got %b exp %b", got, 8'b0000_0000);
            end
        end
    endtask

    task automatic test_acquire();
        logic [7:0] got, exp;
        int rise;
        rise = -1;
        oen_in = 8'h04;
        for (int n = 1; n <= 16; n++) begin
            miso_in = 8'($urandom);
            tick();
            if (rise < 0 && oen_out === 1'b1) rise = n;
            got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
            exp = {m_oen_out, m_miso_out, m_valid, m_idx, m_contention, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL acquire_cycle%0d got %b exp %b", n, got, exp);
            end
        end
        checks++;
        if (rise !== SYNC + 1 + G) begin
            errors++;
            $display("FAIL acquire_latency got %0d exp %0d", rise, SYNC + 1 + G);
        end
        checks++;
        if (owner_idx !== 3'd2) begin
            errors++;
            $display("FAIL acquire_owner got %0d exp 2", owner_idx);
        end
    endtask

    task automatic test_handover();
        logic [7:0] got, exp;
        int lows;
        lows = 0;
        oen_in = 8'h10;
        for (int n = 1; n <= 14; n++) begin
            miso_in = 8'($urandom);
            tick();
            if (oen_out === 1'b0) lows++;
            got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
            exp = {m_oen_out, m_miso_out, m_valid, m_idx, m_contention, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL handover_cycle%0d got %b exp %b", n, got, exp);
            end
        end
        checks++;
        if (lows !== 1 + G) begin
            errors++;
            $display("FAIL handover_gap got %0d exp %0d", lows, 1 + G);
        end
        checks++;
        if ({oen_out, owner_idx} !== 4'b1_100) begin
            errors++;
            $display("FAIL handover_owner got %b exp %b", {oen_out, owner_idx}, 4'b1_100);
        end
    endtask

    task automatic test_contention();
        logic [7:0] got, exp;
        int pulses;
        int drove;
        pulses = 0; drove = 0;
        oen_in = 8'h00;
        repeat (6) tick();
        oen_in = 8'h41;
        for (int n = 1; n <= 6; n++) begin
            miso_in = 8'($urandom);
            tick();
            if (contention === 1'b1) pulses++;
            if (oen_out === 1'b1) drove++;
            got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
            exp = {m_oen_out, m_miso_out, m_valid, m_idx, m_contention, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL contention_cycle%0d got %b exp %b", n, got, exp);
            end
        end
        checks++;
        if (pulses !== 4 || drove !== 0) begin
            errors++;
            $display("FAIL contention_pulses got %0d/%0d exp 4/0", pulses, drove);
        end
        oen_in = 8'h00; err_clr = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
            exp = {m_oen_out, m_miso_out, m_valid, m_idx, m_contention, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL contention_clr%0d got %b exp %b", n, got, exp);
            end
        end
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL contention_cleared got %b exp 0", err_sticky);
        end
    endtask

    task automatic test_guard_drop();
        logic [7:0] got, exp;
        int drove;
        int saw_valid;
        drove = 0; saw_valid = 0;
        oen_in = 8'h08;
        for (int n = 1; n <= 8; n++) begin
            if (n == 3) oen_in = 8'h00;
            miso_in = 8'($urandom);
            tick();
            if (oen_out === 1'b1) drove++;
            if (owner_valid === 1'b1) saw_valid = 1;
            got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
            exp = {m_oen_out, m_miso_out, m_valid, m_idx, m_contention, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL guard_drop_cycle%0d got %b exp %b", n, got, exp);
            end
        end
        checks++;
        if (drove !== 0 || saw_valid !== 1) begin
            errors++;
            $display("FAIL guard_drop_drive got %0d/%0d exp 0/1", drove, saw_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp, pat;
        int a, b, hold, kind;
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(3, 0);
            a = $urandom_range(7, 0);
            b = (a + 1 + $urandom_range(6, 0)) % 8;
            case (kind)
                0:       pat = 8'h00;
                3:       pat = (8'd1 << a) | (8'd1 << b);
                default: pat = 8'd1 << a;
            endcase
            oen_in = pat;
            hold = $urandom_range(10, 1);
            for (int h = 0; h < hold; h++) begin
                miso_in = 8'($urandom);
                err_clr = ($urandom_range(7, 0) == 0);
                tick();
                got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
                exp = {m_oen_out, m_miso_out, m_valid, m_idx, m_contention, m_err};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_seg%0d got %b exp %b", seg, got, exp);
                end
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
                checks++;
                if (contention_cnt !== 2'(m_cnt)) begin
                    errors++;
                    $display("FAIL random_cnt got %0d exp %0d", contention_cnt, m_cnt);
                end
`endif
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] got;
        int rise;
        rise = -1;
        oen_in = 8'h00;
        repeat (5) tick();
        oen_in = 8'h04;
        repeat (8) tick();
        checks++;
        if (oen_out !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_active got %b exp 1", oen_out);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {oen_out, miso_out, owner_valid, owner_idx, contention, err_sticky};
        checks++;
        if (got !== 8'b0000_0000) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", got, 8'b0000_0000);
        end
        model_clear();
        @(negedge clk);
        oen_in = 8'h01; miso_in = 8'hFF;
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (rise < 0 && oen_out === 1'b1) rise = n;
        end
        checks++;
        if (rise !== SYNC + 1 + G || {miso_out, owner_idx} !== 4'b1_000) begin
            errors++;
            $display("FAIL async_reacquire got %0d/%b exp %0d/%b", rise, {miso_out, owner_idx}, SYNC + 1 + G, 4'b1_000);
        end
    endtask

`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
    task automatic test_counter();
        oen_in = 8'h00;
        repeat (4) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        oen_in = 8'h41;
        repeat (5) tick();
        oen_in = 8'h00;
        repeat (4) tick();
        checks++;
        if (contention_cnt !== 2'd3) begin
            errors++;
            $display("FAIL counter_saturate got %0d exp 3", contention_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (contention_cnt !== 2'd0) begin
            errors++;
            $display("FAIL counter_clear got %0d exp 0", contention_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_acquire();
        test_handover();
        test_contention();
        test_guard_drop();
        test_random();
        test_async_reset();
`ifdef SPI_MISO_ARB_CONTENTION_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
